// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared encodings and widths for the program-counter sequencer
package pcseq_defs;

  localparam int PC_W = 8;

  localparam logic [1:0] BR_REL  = 2'b00;
  localparam logic [1:0] BR_ABS  = 2'b01;
  localparam logic [1:0] BR_CALL = 2'b10;
  localparam logic [1:0] BR_RET  = 2'b11;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    DECIDE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_target_adder.sv
// rtl/pc_target_adder.sv - pc plus signed 8-bit offset, wrapping modulo 256
module pc_target_adder
  import pcseq_defs::*;
(
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_imm,
  output logic [PC_W-1:0] o_target
);

  // Two's-complement offset: a plain modulo-256 add yields the signed result.
  assign o_target = i_pc + i_imm;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and fetch/decide sequencer; PCSEQ_RAS_EN adds a return-address stack
module pc_sequencer
  import pcseq_defs::*;
#(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter int         RAS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  output logic       instr_valid,
  input  logic       stall,
  input  logic       br_valid,
  input  logic       br_taken,
  input  logic [1:0] br_kind,
  input  logic [7:0] br_imm,
  output logic [7:0] pc,
  output logic       flush,
  output logic       ras_err
);

  seq_state_t      r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_inc, w_target;
  logic            r_instr_valid, r_flush, w_decide;

`ifdef PCSEQ_RAS_EN
  localparam int RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [RAS_AW:0] RAS_CNT_FULL = (RAS_AW+1)'(RAS_DEPTH);
  localparam logic [RAS_AW-1:0] RAS_WP_LAST = RAS_AW'(RAS_DEPTH - 1);

  logic [PC_W-1:0]   r_ras [RAS_DEPTH];
  logic [RAS_AW-1:0] r_ras_wp, w_ras_wp_inc, w_ras_wp_dec;
  logic [RAS_AW:0]   r_ras_cnt;
  logic              r_ras_err, w_push, w_pop, w_ras_empty, w_ras_full;
  logic [PC_W-1:0]   w_ras_top;
`endif

  pc_target_adder u_target_adder (
    .i_pc     (r_pc),
    .i_imm    (br_imm),
    .o_target (w_target)
  );

  assign w_pc_inc = r_pc + 8'd1;
  // The first DECIDE cycle is the instr_valid cycle; the decision is made after it.
  assign w_decide = (r_state == DECIDE) && !r_instr_valid && !stall;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
`ifdef PCSEQ_RAS_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
`endif
    case (r_state)
      BOOT:  w_state_nxt = FETCH;
      FETCH: if (imem_ack) w_state_nxt = DECIDE;
      DECIDE: begin
        if (w_decide) begin
          w_state_nxt = FETCH;
          w_pc_nxt    = w_pc_inc;
          if (br_valid) begin
            case (br_kind)
              BR_REL:  if (br_taken) w_pc_nxt = w_target;
              BR_ABS:  w_pc_nxt = br_imm;
`ifdef PCSEQ_RAS_EN
              BR_CALL: begin
                w_pc_nxt = br_imm;
                w_push   = 1'b1;
              end
              default: begin
                w_pop = 1'b1;
                if (!w_ras_empty) w_pc_nxt = w_ras_top;
              end
`else
              BR_CALL: w_pc_nxt = br_imm;
              default: w_pc_nxt = w_pc_inc;
`endif
            endcase
          end
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_flush       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr_valid <= (r_state == FETCH) && imem_ack;
      r_flush       <= w_decide && (w_pc_nxt != w_pc_inc);
    end
  end

`ifdef PCSEQ_RAS_EN
  assign w_ras_empty  = (r_ras_cnt == '0);
  assign w_ras_full   = (r_ras_cnt == RAS_CNT_FULL);
  assign w_ras_wp_inc = (r_ras_wp == RAS_WP_LAST) ? '0 : r_ras_wp + 1'b1;
  assign w_ras_wp_dec = (r_ras_wp == '0) ? RAS_WP_LAST : r_ras_wp - 1'b1;
  assign w_ras_top    = r_ras[w_ras_wp_dec];

  // Circular buffer: a push when full lands on the oldest slot and keeps the count saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ras_wp  <= '0;
      r_ras_cnt <= '0;
      r_ras_err <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else begin
      r_ras_err <= (w_push && w_ras_full) || (w_pop && w_ras_empty);
      if (w_push) begin
        r_ras[r_ras_wp] <= w_pc_inc;
        r_ras_wp        <= w_ras_wp_inc;
        if (!w_ras_full) r_ras_cnt <= r_ras_cnt + 1'b1;
      end else if (w_pop && !w_ras_empty) begin
        r_ras_wp  <= w_ras_wp_dec;
        r_ras_cnt <= r_ras_cnt - 1'b1;
      end
    end
  end

  assign ras_err = r_ras_err;
`else
  assign ras_err = 1'b0;
`endif

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign flush       = r_flush;
  assign pc          = r_pc;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the 8-bit program counter and sequences instruction fetch for the 8-bit processor. Runs a fetch/decide loop against instruction memory with a req/ack handshake. Resolves the next PC from decode's branch request: sequential, PC-relative (through a PC+immediate target adder), absolute, or call/return. Sits between the decode stage and instruction memory.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.
RAS_DEPTH, 4, return-stack entries; used only with PCSEQ_RAS_EN.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
imem_req  out  1  fetch request to instruction memory
imem_addr  out  8  fetch address; equals pc while imem_req=1
imem_ack  in  1  memory has returned the instruction for imem_addr
instr_valid  out  1  one-cycle pulse; the instruction at pc is available to decode
stall  in  1  decode not ready; hold in DECIDE
br_valid  in  1  decode presents a control-flow op this cycle (sampled in DECIDE)
br_taken  in  1  condition result; ignored for kinds 01/10/11
br_kind  in  2  00 relative, 01 absolute, 10 call, 11 return
br_imm  in  8  relative offset (two's complement) or absolute target
pc  out  8  current PC
flush  out  1  one-cycle pulse when the next PC is not pc+1
ras_err  out  1  one-cycle pulse on return-stack overflow or underflow

Behaviour:
- Reset (asynchronous): state=BOOT, pc=RESET_PC, imem_req=0, instr_valid=0, flush=0, ras_err=0, stack pointer=0.
- BOOT: one cycle, then FETCH.
- FETCH: imem_req=1, imem_addr=pc. Hold both until imem_ack=1. On ack, drop imem_req, pulse instr_valid on the next cycle, and go to DECIDE.
- DECIDE: if stall=1, remain in DECIDE with pc held. Otherwise compute next PC this cycle, register it, and go to FETCH, so the next request starts the following cycle:
  - br_valid=0: pc+1.
  - kind 00: if br_taken=1, pc + br_imm (signed, modulo 256); else pc+1.
  - kind 01: br_imm.
  - kind 10/11: see Optional Feature.
- flush pulses for one cycle, coincident with the pc update, whenever next PC ≠ pc+1 (mod 256).
- All arithmetic is 8-bit with wrap-around: 0xFF+1 = 0x00; 0x03+0x84 = 0x87.
- An imem_ack arriving outside FETCH is ignored.
- The br_* inputs are ignored outside DECIDE.
- Latency: minimum 3 cycles per instruction (FETCH with same-cycle ack, instr_valid cycle, DECIDE).
- Reset asserted mid-fetch drops imem_req immediately; no pending request survives reset.

Optional Feature:
- Macro PCSEQ_RAS_EN.
- Defined: RAS_DEPTH-entry return-address stack.
  - Call (10) pushes pc+1 and jumps to br_imm.
  - Return (11) pops into pc.
  - Push when full: circular overwrite of the oldest entry, pulse ras_err.
  - Pop when empty: next PC = pc+1, pulse ras_err.
  - Simultaneous reset clears the stack.
- Undefined: call behaves as absolute jump (no push), return behaves as pc+1, and ras_err is tied to 0.

Decomposition:
- Shared package/header pcseq_defs holds:
  - br_kind encodings BR_REL=2'b00, BR_ABS=2'b01, BR_CALL=2'b10, BR_RET=2'b11;
  - state encodings BOOT, FETCH, DECIDE;
  - the 8-bit width constant.
- One sub-module, pc_target_adder: combinational 8-bit pc + signed imm with wrap. Instantiated once in pc_sequencer.

Test Plan:
- Reset then fetch: rst pulse, imem_ack=1 in the first FETCH cycle → imem_addr=0x00, instr_valid one cycle after ack, pc=0x00.
- Sequential with stall: pc=0x0F, br_valid=0, stall=1 for 3 cycles then 0 → pc holds 0x0F through the stall, then 0x10, flush=0.
- Relative taken: pc=0x01, kind 00, br_taken=1, imm=0x80 → pc=0x81, flush=1. Second case: pc=0x61, imm=0x8C → pc=0xED. Third case: pc=0x03, imm=0x84 → pc=0x87.
- Relative not taken and wrap: pc=0xFF, kind 00, br_taken=0 → pc=0x00, flush=0.
- Delayed ack: imem_ack held low 4 cycles → imem_req and imem_addr stable for all 4 cycles, no instr_valid until the ack arrives.
- RAS (macro defined): call at pc=0x10 with imm=0x40 → pc=0x40; later return → pc=0x11. Five calls with no returns → ras_err pulses on the fifth. Return on an empty stack → ras_err=1 and pc=pc+1.
